// File: rtl/seq_gen.sv
// seq_gen: steps a 16-bit value (0..9999) through one of eight programs at a
// selectable rate while the run input is high. A program button loads the new
// program's seed. A rate button cycles the divider period BASE_PERIOD >> modulo.
module seq_gen #(
  parameter int BASE_PERIOD = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        btn_prog,
  input  logic        btn_mod,
  output logic [2:0]  prog,
  output logic [1:0]  modulo,
  output logic [15:0] data_2,
  output logic        running
);

  localparam int CW = $clog2(BASE_PERIOD + 1);
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            running_q, running_d;
  logic            btn_prog_q, btn_mod_q;
  logic            prog_press_q, mod_press_q;
  logic [2:0]      prog_q, prog_d;
  logic [1:0]      mod_q, mod_d;
  logic [15:0]     data_q, data_d;
  logic [15:0]     aux_q, aux_d;
  logic            dir_q, dir_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [CW-1:0]   period_s;
  logic [CW-1:0]   last_s;
  logic            tick_s;
  logic [2:0]      prog_inc_s;
  logic [16:0]     fib_sum_s;
  logic [15:0]     step_data_s;
  logic [15:0]     step_aux_s;
  logic            step_dir_s;

  // Starting value of each program.
  function automatic logic [15:0] seed_of(input logic [2:0] p);
    logic [15:0] s;
    case (p)
      3'd1:    s = 16'd9999;
      3'd3:    s = 16'd1;
      3'd5:    s = 16'd1;
      default: s = 16'd0;
    endcase
    return s;
  endfunction

  assign period_s   = CW'(BASE_PERIOD >> mod_q);
  assign last_s     = period_s - CW'(1);
  assign tick_s     = (state_q == S_RUN) && (cnt_q == last_s);
  assign prog_inc_s = prog_q + 3'd1;

  // Next value of the current program; every rule keeps data inside 0..9999.
  always_comb begin
    step_data_s = data_q;
    step_aux_s  = aux_q;
    step_dir_s  = dir_q;
    fib_sum_s   = {1'b0, data_q} + {1'b0, aux_q};
    case (prog_q)
      3'd0: begin
        if (data_q >= 16'd9999) step_data_s = 16'd0;
        else                    step_data_s = data_q + 16'd1;
      end
      3'd1: begin
        if (data_q == 16'd0) step_data_s = 16'd9999;
        else                 step_data_s = data_q - 16'd1;
      end
      3'd2: begin
        if (data_q >= 16'd9998) step_data_s = 16'd0;
        else                    step_data_s = data_q + 16'd2;
      end
      3'd3: begin
        if (data_q >= 16'd9999) step_data_s = 16'd1;
        else                    step_data_s = data_q + 16'd2;
      end
      3'd4: begin
        // aux is the value about to be shown; restart before it passes 9999,
        // so 6765 is the largest value displayed.
        if ((aux_q > 16'd9999) || fib_sum_s[16]) begin
          step_data_s = 16'd0;
          step_aux_s  = 16'd1;
        end else begin
          step_data_s = aux_q;
          step_aux_s  = fib_sum_s[15:0];
        end
      end
      3'd5: begin
        if ((data_q > 16'd4999) || (data_q == 16'd0)) step_data_s = 16'd1;
        else                                          step_data_s = {data_q[14:0], 1'b0};
      end
      3'd6: begin
        if (data_q >= 16'd9801) begin
          step_data_s = 16'd0;
          step_aux_s  = 16'd1;
        end else begin
          step_data_s = data_q + aux_q;
          step_aux_s  = aux_q + 16'd2;
        end
      end
      3'd7: begin
        if (dir_q == DIR_UP) begin
          if (data_q >= 16'd9999) begin
            step_data_s = 16'd9998;
            step_dir_s  = DIR_DOWN;
          end else begin
            step_data_s = data_q + 16'd1;
          end
        end else begin
          if (data_q == 16'd0) begin
            step_data_s = 16'd1;
            step_dir_s  = DIR_UP;
          end else begin
            step_data_s = data_q - 16'd1;
          end
        end
      end
      default: begin
        step_data_s = data_q;
      end
    endcase
  end

  // FSM next state, divider and value/selection updates with event priority.
  always_comb begin
    state_d   = state_q;
    running_d = running_q;
    cnt_d     = cnt_q;
    prog_d    = prog_q;
    mod_d     = mod_q;
    data_d    = data_q;
    aux_d     = aux_q;
    dir_d     = dir_q;

    if (run) state_d = S_RUN;
    else     state_d = S_IDLE;
    running_d = (state_d == S_RUN);

    if ((state_q != S_RUN) || prog_press_q || mod_press_q || tick_s) cnt_d = '0;
    else                                                             cnt_d = cnt_q + CW'(1);

    if (mod_press_q) mod_d = mod_q + 2'd1;
    else             mod_d = mod_q;

    // A program change reloads the seed and overrides a coincident step;
    // a rate change drops a coincident step.
    if (prog_press_q) begin
      prog_d = prog_inc_s;
      data_d = seed_of(prog_inc_s);
      aux_d  = 16'd1;
      dir_d  = DIR_UP;
    end else if (tick_s && !mod_press_q) begin
      data_d = step_data_s;
      aux_d  = step_aux_s;
      dir_d  = step_dir_s;
    end else begin
      data_d = data_q;
    end
  end

  // Button history and registered press pulses; history resets high so a
  // button held through reset is not seen as a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_prog_q   <= 1'b1;
      btn_mod_q    <= 1'b1;
      prog_press_q <= 1'b0;
      mod_press_q  <= 1'b0;
    end else begin
      btn_prog_q   <= btn_prog;
      btn_mod_q    <= btn_mod;
      prog_press_q <= btn_prog & ~btn_prog_q;
      mod_press_q  <= btn_mod & ~btn_mod_q;
    end
  end

  // State, divider and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      running_q <= 1'b0;
      cnt_q     <= '0;
      prog_q    <= 3'd0;
      mod_q     <= 2'd0;
      data_q    <= 16'd0;
      aux_q     <= 16'd1;
      dir_q     <= DIR_UP;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      cnt_q     <= cnt_d;
      prog_q    <= prog_d;
      mod_q     <= mod_d;
      data_q    <= data_d;
      aux_q     <= aux_d;
      dir_q     <= dir_d;
    end
  end

  assign prog    = prog_q;
  assign modulo  = mod_q;
  assign data_2  = data_q;
  assign running = running_q;

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen with BASE_PERIOD=8; inputs driven and outputs
// sampled on the falling clock edge.
module tb_seq_gen;

  logic        clk;
  logic        rst;
  logic        run;
  logic        btn_prog;
  logic        btn_mod;
  logic [2:0]  prog;
  logic [1:0]  modulo;
  logic [15:0] data_2;
  logic        running;

  int n_cmp;
  int n_err;

  seq_gen #(.BASE_PERIOD(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .btn_prog (btn_prog),
    .btn_mod  (btn_mod),
    .prog     (prog),
    .modulo   (modulo),
    .data_2   (data_2),
    .running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_prog();
    btn_prog = 1'b1;
    cycles(2);
    btn_prog = 1'b0;
    cycles(2);
  endtask

  task automatic press_mod();
    btn_mod = 1'b1;
    cycles(2);
    btn_mod = 1'b0;
    cycles(2);
  endtask

  // Advance until data_2 equals val or the budget runs out; the final
  // comparison fails if the value never appeared.
  task automatic wait_data(input int val, input int budget, input string tag);
    int n;
    n = 0;
    while ((data_2 !== 16'(val)) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(data_2), 32'(val));
  endtask

  initial begin
    int fib[$];
    int a;
    int b;
    int t;

    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b0;
    run      = 1'b0;
    btn_prog = 1'b0;
    btn_mod  = 1'b0;

    // Reset values
    cycles(3);
    check_eq("rst_prog",    32'(prog),    32'd0);
    check_eq("rst_modulo",  32'(modulo),  32'd0);
    check_eq("rst_data",    32'(data_2),  32'd0);
    check_eq("rst_running", 32'(running), 32'd0);
    rst = 1'b1;
    cycles(3);

    // Program 0, period 8
    run = 1'b1;
    @(negedge clk);
    check_eq("run_running", 32'(running), 32'd1);
    check_eq("p0_start",    32'(data_2),  32'd0);
    cycles(7);
    check_eq("p0_hold7",    32'(data_2),  32'd0);
    @(negedge clk);
    check_eq("p0_step1",    32'(data_2),  32'd1);
    cycles(8);
    check_eq("p0_step2",    32'(data_2),  32'd2);

    // Rate select to 3 (period 1), then wrap 9999 -> 0
    press_mod();
    press_mod();
    press_mod();
    check_eq("mod3", 32'(modulo), 32'd3);
    a = int'(data_2);
    @(negedge clk);
    check_eq("p1_every_cycle", 32'(data_2), 32'((a == 9999) ? 0 : a + 1));
    wait_data(9999, 12000, "p0_reach_9999");
    @(negedge clk);
    check_eq("p0_wrap", 32'(data_2), 32'd0);

    // Pause: one last step lands on the edge that leaves S_RUN, then hold
    run = 1'b0;
    @(negedge clk);
    check_eq("pause_running", 32'(running), 32'd0);
    check_eq("pause_last",    32'(data_2),  32'd1);
    cycles(5);
    check_eq("pause_hold",    32'(data_2),  32'd1);

    // Fibonacci program
    press_prog();
    press_prog();
    press_prog();
    press_prog();
    check_eq("prog4",      32'(prog),   32'd4);
    check_eq("prog4_seed", 32'(data_2), 32'd0);
    a = 0;
    b = 1;
    while (a <= 9999) begin
      fib.push_back(a);
      t = a + b;
      a = b;
      b = t;
    end
    fib.push_back(0);
    fib.push_back(1);
    run = 1'b1;
    for (int i = 0; i < fib.size(); i++) begin
      @(negedge clk);
      check_eq($sformatf("fib_%0d", i), 32'(data_2), 32'(fib[i]));
    end

    // Ping-pong program
    run = 1'b0;
    cycles(2);
    press_prog();
    press_prog();
    press_prog();
    check_eq("prog7",      32'(prog),   32'd7);
    check_eq("prog7_seed", 32'(data_2), 32'd0);
    run = 1'b1;
    wait_data(9999, 12000, "pp_top");
    @(negedge clk);
    check_eq("pp_down1", 32'(data_2), 32'd9998);
    @(negedge clk);
    check_eq("pp_down2", 32'(data_2), 32'd9997);
    wait_data(0, 12000, "pp_bottom");
    @(negedge clk);
    check_eq("pp_up", 32'(data_2), 32'd1);

    // Fourth rate press wraps modulo to 0
    press_mod();
    check_eq("mod_wrap", 32'(modulo), 32'd0);

    // Program press coinciding with the tick: seed wins, no step
    run = 1'b0;
    cycles(2);
    press_prog();
    press_prog();
    check_eq("prog1",      32'(prog),   32'd1);
    check_eq("prog1_seed", 32'(data_2), 32'd9999);
    run = 1'b1;
    cycles(7);
    btn_prog = 1'b1;
    @(negedge clk);
    check_eq("tick_pre", 32'(data_2), 32'd9999);
    btn_prog = 1'b0;
    @(negedge clk);
    check_eq("tick_prog",  32'(prog),   32'd2);
    check_eq("tick_seed",  32'(data_2), 32'd0);
    cycles(7);
    check_eq("p2_hold",    32'(data_2), 32'd0);
    @(negedge clk);
    check_eq("p2_step",    32'(data_2), 32'd2);

    // Pause at 5, resume: 6 appears 8 cycles after S_RUN is re-entered
    run = 1'b0;
    cycles(2);
    for (int i = 0; i < 6; i++) press_prog();
    check_eq("prog0_again", 32'(prog), 32'd0);
    run = 1'b1;
    wait_data(5, 200, "reach_5");
    run = 1'b0;
    @(negedge clk);
    check_eq("stop_running", 32'(running), 32'd0);
    check_eq("stop_data",    32'(data_2),  32'd5);
    cycles(20);
    check_eq("idle_hold",    32'(data_2),  32'd5);
    run = 1'b1;
    cycles(8);
    check_eq("resume_hold",  32'(data_2),  32'd5);
    @(negedge clk);
    check_eq("resume_step",  32'(data_2),  32'd6);

    // Program and rate presses in the same cycle both apply
    run = 1'b0;
    cycles(2);
    btn_prog = 1'b1;
    btn_mod  = 1'b1;
    cycles(2);
    btn_prog = 1'b0;
    btn_mod  = 1'b0;
    cycles(2);
    check_eq("both_prog", 32'(prog),   32'd1);
    check_eq("both_mod",  32'(modulo), 32'd1);
    check_eq("both_seed", 32'(data_2), 32'd9999);

    // Reset mid-run with btn_prog held through the release
    run = 1'b1;
    cycles(20);
    btn_prog = 1'b1;
    rst = 1'b0;
    #1;
    check_eq("midrst_data",    32'(data_2),  32'd0);
    check_eq("midrst_running", 32'(running), 32'd0);
    check_eq("midrst_prog",    32'(prog),    32'd0);
    check_eq("midrst_modulo",  32'(modulo),  32'd0);
    cycles(3);
    rst = 1'b1;
    cycles(5);
    check_eq("held_btn_prog", 32'(prog), 32'd0);
    btn_prog = 1'b0;
    cycles(3);
    check_eq("held_btn_release", 32'(prog), 32'd0);
    press_prog();
    check_eq("rearmed_press", 32'(prog), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
